pico_ctrl: RTL and testbench
============================

Name: pico_ctrl

Overview:
- Fetch/execute controller for the picoMIPS core, directly downstream of program memory and upstream of the program counter.
- Latches the instruction read at the current PC into an instruction register (IR).
- Decodes the IR and drives the PC's pc_inc / pc_relbranch / pc_absbranch / branchaddr inputs, plus datapath controls.
- Runs a small FSM that sequences the two-cycle fetch/execute, a handshaked input-wait and a halt.

Parameters:
- p, 6, PC/branch-address width; must be ≤ 6 (fits the offset field).
- iw, 16, instruction width; fixed field layout requires iw = 16.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr  in  iw  program-memory data at current pc_out, combinational read
- z_flag  in  1  ALU zero flag from the previous ALU op
- in_valid  in  1  external input word available
- in_ready  out  1  controller waiting for input
- pc_inc  out  1  PC +1
- pc_relbranch  out  1  PC += branchaddr (modulo 2^p)
- pc_absbranch  out  1  PC = branchaddr
- branchaddr  out  p  IR[p-1:0]
- alu_func  out  3  IR[14:12] (low opcode bits), valid when reg_we=1
- imm_sel  out  1  ALU B operand = immediate
- in_sel  out  1  register write data = external input
- reg_we  out  1  register-file write enable, one-cycle pulse
- rd_addr  out  3  IR[11:9]
- rs_addr  out  3  IR[8:6]
- imm  out  6  IR[5:0]
- halted  out  1  FSM in HALT

Behaviour:
- Instruction format: op[15:12], rd[11:9], rs[8:6], imm/offset[5:0].
- Opcodes:
  - 0 NOP, 1 ADD, 2 ADDI, 3 MULI, 4 BEQ, 5 BNE, 6 JMP, 7 IN, F HALT.
  - All other opcodes execute as NOP.
- Reset (sync, active-high, wins over all other inputs):
  - state = FETCH, IR = 0.
  - All outputs 0, including halted and in_ready.
- States: FETCH, EXEC, WAIT, HALT.
- FETCH:
  - IR <= instr.
  - All pc_* = 0, reg_we = 0.
  - Next state EXEC.
  - PC is unchanged, so pc_out stays the address of the instruction in IR.
- EXEC (outputs combinational from state and IR):
  - NOP: pc_inc. Next FETCH.
  - ADD: reg_we, imm_sel=0, pc_inc. Next FETCH.
  - ADDI, MULI: reg_we, imm_sel=1, pc_inc. Next FETCH.
  - BEQ: z_flag=1 -> pc_relbranch, else pc_inc. Next FETCH.
  - BNE: z_flag=0 -> pc_relbranch, else pc_inc. Next FETCH.
  - Branch offset is two's complement relative to the branch instruction's own address. Offset 0 is a self-loop.
  - JMP: pc_absbranch. Next FETCH.
  - IN: no outputs asserted. Next WAIT.
  - HALT: no outputs asserted. Next HALT.
- WAIT:
  - in_ready = 1.
  - On in_valid = 1 in the same cycle: reg_we=1, in_sel=1, pc_inc=1, next FETCH.
  - Otherwise hold all pc_* = 0 and stay in WAIT.
- HALT:
  - halted = 1, all other outputs 0.
  - Exit only through reset.
- Invariants:
  - At most one of pc_inc, pc_relbranch, pc_absbranch is high in any cycle. All are zero outside EXEC/WAIT.
  - in_valid outside WAIT is ignored; no input word is consumed.
  - rd_addr, rs_addr, imm, branchaddr, alu_func always reflect IR; their values are meaningful only while a strobe is high.
- Latency:
  - Normal instruction: 2 cycles.
  - IN: 3 cycles minimum, plus in_valid wait time.
- Reset mid-operation:
  - Reset during WAIT drops in_ready on the next edge; the pending input is discarded.
  - Reset during EXEC suppresses nothing already sampled; state is FETCH next cycle.

Decomposition:
- Shared package pico_pkg:
  - opcode enum (4-bit).
  - ctrl state enum.
  - field position constants (OP_HI/LO, RD, RS, IMM).
- One natural sub-module: pico_decode, combinational, mapping IR opcode + z_flag to a control bundle.
- The FSM and IR stay in pico_ctrl.

Test Plan:
- Reset:
  - Assert reset 2 cycles with instr=16'h1000 -> all outputs 0, halted=0.
  - Release -> FETCH, then EXEC with pc_inc=1 and reg_we=1 on cycle 2.
- ADDI:
  - instr=16'h2A45 (ADDI rd=5, rs=1, imm=5) -> EXEC: reg_we=1, imm_sel=1, rd_addr=5, rs_addr=1, imm=5, pc_inc=1.
- BEQ, p=6, instr=16'h403E (offset -2):
  - z_flag=1 -> pc_relbranch=1, branchaddr=6'h3E, pc_inc=0.
  - z_flag=0 -> pc_inc=1 only.
- JMP:
  - instr=16'h6011 -> pc_absbranch=1, branchaddr=6'h11.
  - Exactly one pc strobe over the whole run (assertion).
- IN handshake:
  - instr=16'h7600; hold in_valid=0 for 5 cycles -> in_ready=1, no pc strobes.
  - Raise in_valid -> same cycle reg_we=1, in_sel=1, pc_inc=1; next cycle in_ready=0.
- HALT and reset during WAIT:
  - instr=16'hF000 -> halted=1 indefinitely with in_valid toggling and no strobes.
  - Separately, reset while in WAIT -> in_ready=0 next cycle, state FETCH.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared types and field positions for the picoMIPS fetch/execute controller.
package pico_pkg;

   // Instruction field positions (16-bit format: op | rd | rs | imm/offset)
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS_HI  = 8;
   localparam int RS_LO  = 6;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_ADDI = 4'h2,
      OP_MULI = 4'h3,
      OP_BEQ  = 4'h4,
      OP_BNE  = 4'h5,
      OP_JMP  = 4'h6,
      OP_IN   = 4'h7,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   // Control bundle produced by the decoder; only meaningful in EXEC.
   typedef struct packed {
      logic pc_inc;
      logic pc_relbranch;
      logic pc_absbranch;
      logic reg_we;
      logic imm_sel;
      logic go_wait;
      logic go_halt;
   } ctrl_t;

endpackage

// File: rtl/pico_decode.sv
// Combinational opcode decoder: IR opcode + zero flag -> EXEC control bundle.
module pico_decode
   import pico_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       z_flag,
   output ctrl_t      ctrl
);

   // Map each opcode to its EXEC-cycle strobes; unknown opcodes behave as NOP.
   always_comb begin
      ctrl = '0;
      case (opcode_e'(opcode))
         OP_NOP: ctrl.pc_inc = 1'b1;
         OP_ADD: begin
            ctrl.reg_we = 1'b1;
            ctrl.pc_inc = 1'b1;
         end
         OP_ADDI, OP_MULI: begin
            ctrl.reg_we  = 1'b1;
            ctrl.imm_sel = 1'b1;
            ctrl.pc_inc  = 1'b1;
         end
         OP_BEQ: begin
            ctrl.pc_relbranch = z_flag;
            ctrl.pc_inc       = ~z_flag;
         end
         OP_BNE: begin
            ctrl.pc_relbranch = ~z_flag;
            ctrl.pc_inc       = z_flag;
         end
         OP_JMP:  ctrl.pc_absbranch = 1'b1;
         OP_IN:   ctrl.go_wait      = 1'b1;
         OP_HALT: ctrl.go_halt      = 1'b1;
         default: ctrl.pc_inc       = 1'b1;
      endcase
   end

endmodule

// File: rtl/pico_ctrl.sv
// picoMIPS fetch/execute controller: instruction register, FSM and PC/datapath strobes.
//
// state | meaning
// FETCH | latch instr into IR, no strobes; PC still points at this instruction
// EXEC  | drive decoded strobes for IR (combinational from state, IR, z_flag)
// WAIT  | IN instruction: in_ready high until in_valid, then write input and step PC
// HALT  | halted high, everything else quiet; left only through reset
module pico_ctrl
   import pico_pkg::*;
#(
   parameter int p  = 6,
   parameter int iw = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [iw-1:0] instr,
   input  logic          z_flag,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          pc_inc,
   output logic          pc_relbranch,
   output logic          pc_absbranch,
   output logic [p-1:0]  branchaddr,
   output logic [2:0]    alu_func,
   output logic          imm_sel,
   output logic          in_sel,
   output logic          reg_we,
   output logic [2:0]    rd_addr,
   output logic [2:0]    rs_addr,
   output logic [5:0]    imm,
   output logic          halted
);

   if (p > 6 || p < 1) begin : g_bad_p
      $error("pico_ctrl: p must be in 1..6");
   end
   if (iw != 16) begin : g_bad_iw
      $error("pico_ctrl: iw must be 16");
   end

   state_e        state;
   logic [iw-1:0] ir;
   ctrl_t         dec;

   pico_decode u_decode (
      .opcode (ir[OP_HI:OP_LO]),
      .z_flag (z_flag),
      .ctrl   (dec)
   );

   // FSM state and instruction register; reset clears both.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_FETCH;
         ir    <= '0;
      end else begin
         case (state)
            ST_FETCH: begin
               ir    <= instr;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (dec.go_halt)      state <= ST_HALT;
               else if (dec.go_wait) state <= ST_WAIT;
               else                  state <= ST_FETCH;
            end
            ST_WAIT: if (in_valid) state <= ST_FETCH;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_FETCH;
         endcase
      end
   end

   // Strobes are combinational so the input handshake completes in the cycle in_valid is seen.
   always_comb begin
      pc_inc       = 1'b0;
      pc_relbranch = 1'b0;
      pc_absbranch = 1'b0;
      reg_we       = 1'b0;
      imm_sel      = 1'b0;
      in_sel       = 1'b0;
      in_ready     = 1'b0;
      halted       = 1'b0;
      case (state)
         ST_EXEC: begin
            pc_inc       = dec.pc_inc;
            pc_relbranch = dec.pc_relbranch;
            pc_absbranch = dec.pc_absbranch;
            reg_we       = dec.reg_we;
            imm_sel      = dec.imm_sel;
         end
         ST_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               reg_we = 1'b1;
               in_sel = 1'b1;
               pc_inc = 1'b1;
            end
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign alu_func   = ir[OP_HI-1:OP_LO];
   assign rd_addr    = ir[RD_HI:RD_LO];
   assign rs_addr    = ir[RS_HI:RS_LO];
   assign imm        = ir[IMM_HI:IMM_LO];
   assign branchaddr = ir[p-1:0];

endmodule

// File: tb/tb_pico_ctrl.sv
// Scoreboard bench for pico_ctrl: expected output vectors are queued as stimulus is driven.
module tb_pico_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] instr = 16'h0000;
   logic        z_flag = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready, pc_inc, pc_relbranch, pc_absbranch;
   logic [5:0]  branchaddr;
   logic [2:0]  alu_func;
   logic        imm_sel, in_sel, reg_we;
   logic [2:0]  rd_addr, rs_addr;
   logic [5:0]  imm;
   logic        halted;

   pico_ctrl #(.p(6), .iw(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .instr        (instr),
      .z_flag       (z_flag),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .pc_inc       (pc_inc),
      .pc_relbranch (pc_relbranch),
      .pc_absbranch (pc_absbranch),
      .branchaddr   (branchaddr),
      .alu_func     (alu_func),
      .imm_sel      (imm_sel),
      .in_sel       (in_sel),
      .reg_we       (reg_we),
      .rd_addr      (rd_addr),
      .rs_addr      (rs_addr),
      .imm          (imm),
      .halted       (halted)
   );

   always #5 clock = ~clock;

   // Strobe bits: {pc_inc, pc_relbranch, pc_absbranch, reg_we, imm_sel, in_sel, in_ready, halted}
   localparam logic [7:0] S_INC   = 8'b1000_0000;
   localparam logic [7:0] S_REL   = 8'b0100_0000;
   localparam logic [7:0] S_ABS   = 8'b0010_0000;
   localparam logic [7:0] S_WE    = 8'b0001_0000;
   localparam logic [7:0] S_IMM   = 8'b0000_1000;
   localparam logic [7:0] S_INSEL = 8'b0000_0100;
   localparam logic [7:0] S_RDY   = 8'b0000_0010;
   localparam logic [7:0] S_HALT  = 8'b0000_0001;

   logic [28:0] sb[$];
   logic [15:0] ir_m = 16'h0000;
   int          tests = 0;
   int          fails = 0;
   int          strobe_cnt = 0;

   function automatic logic [28:0] mk(input logic [7:0] s, input logic [15:0] ir);
      return {s, ir[14:12], ir[11:9], ir[8:6], ir[5:0], ir[5:0]};
   endfunction

   function automatic logic [28:0] obs();
      return {pc_inc, pc_relbranch, pc_absbranch, reg_we, imm_sel, in_sel, in_ready, halted,
              alu_func, rd_addr, rs_addr, imm, branchaddr};
   endfunction

   // Reference behaviour of the EXEC cycle, straight from the opcode table.
   function automatic logic [7:0] exec_exp(input logic [15:0] ir, input logic z);
      case (ir[15:12])
         4'h0:       return S_INC;
         4'h1:       return S_WE | S_INC;
         4'h2, 4'h3: return S_WE | S_IMM | S_INC;
         4'h4:       return z ? S_REL : S_INC;
         4'h5:       return z ? S_INC : S_REL;
         4'h6:       return S_ABS;
         4'h7:       return 8'h00;
         4'hF:       return 8'h00;
         default:    return S_INC;
      endcase
   endfunction

   // PC strobe monitor: never more than one at a time, and a running strobe count.
   always @(negedge clock) begin
      if ({pc_inc, pc_relbranch, pc_absbranch} != 3'b000) strobe_cnt++;
      if ({pc_inc, pc_relbranch, pc_absbranch} == 3'b011 || {pc_inc, pc_relbranch, pc_absbranch} == 3'b101 ||
          {pc_inc, pc_relbranch, pc_absbranch} == 3'b110 || {pc_inc, pc_relbranch, pc_absbranch} == 3'b111) begin
         fails++;
         $display("FAIL pc_onehot at %0t: got %b required at most one high", $time,
                  {pc_inc, pc_relbranch, pc_absbranch});
      end
   end

   task automatic test_reset();
      logic [28:0] e, g;
      reset = 1'b1;
      instr = 16'h1000;
      @(posedge clock); #1;
      @(posedge clock); #1;
      sb.push_back(mk(8'h00, 16'h0000));
      @(negedge clock);
      e = sb.pop_front(); g = obs(); tests++;
      if (g !== e) begin fails++; $display("FAIL reset_outputs: got %h expected %h", g, e); end
      @(posedge clock); #1;
      reset = 1'b0;
      ir_m = 16'h0000;
      for (int c = 0; c < 2; c++) begin
         sb.push_back(c == 0 ? mk(8'h00, ir_m) : mk(S_WE | S_INC, 16'h1000));
         @(negedge clock);
         e = sb.pop_front(); g = obs(); tests++;
         if (g !== e) begin fails++; $display("FAIL reset_release cycle %0d: got %h expected %h", c, g, e); end
         @(posedge clock); #1;
         if (c == 0) ir_m = 16'h1000;
      end
   endtask

   task automatic test_decode();
      logic [28:0] e, g;
      logic [16:0] tbl [10];
      tbl = '{{1'b0, 16'h1253}, {1'b0, 16'h2A45}, {1'b1, 16'h3FFF}, {1'b1, 16'h403E},
              {1'b0, 16'h403E}, {1'b0, 16'h5005}, {1'b1, 16'h5005}, {1'b0, 16'h0ABC},
              {1'b1, 16'h8123}, {1'b0, 16'hE7C1}};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < 2; c++) begin
            instr  = tbl[i][15:0];
            z_flag = tbl[i][16];
            sb.push_back(c == 0 ? mk(8'h00, ir_m) : mk(exec_exp(tbl[i][15:0], tbl[i][16]), tbl[i][15:0]));
            @(negedge clock);
            e = sb.pop_front(); g = obs(); tests++;
            if (g !== e) begin
               fails++;
               $display("FAIL decode instr=%h z=%b cycle %0d: got %h expected %h", tbl[i][15:0], tbl[i][16], c, g, e);
            end
            @(posedge clock); #1;
            if (c == 0) ir_m = tbl[i][15:0];
         end
      end
      z_flag = 1'b0;
   endtask

   task automatic test_jmp();
      logic [28:0] e, g;
      strobe_cnt = 0;
      for (int c = 0; c < 2; c++) begin
         instr = 16'h6011;
         sb.push_back(c == 0 ? mk(8'h00, ir_m) : mk(S_ABS, 16'h6011));
         @(negedge clock);
         e = sb.pop_front(); g = obs(); tests++;
         if (g !== e) begin fails++; $display("FAIL jmp cycle %0d: got %h expected %h", c, g, e); end
         @(posedge clock); #1;
         if (c == 0) ir_m = 16'h6011;
      end
      tests++;
      if (strobe_cnt !== 1) begin fails++; $display("FAIL jmp_strobe_count: got %0d expected 1", strobe_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [28:0] e, g;
      logic [15:0] seq [4];
      seq = '{16'h1111, 16'h6022, 16'h2003, 16'h4001};
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 2; c++) begin
            instr  = seq[i];
            z_flag = i[0];
            sb.push_back(c == 0 ? mk(8'h00, ir_m) : mk(exec_exp(seq[i], i[0]), seq[i]));
            @(negedge clock);
            e = sb.pop_front(); g = obs(); tests++;
            if (g !== e) begin fails++; $display("FAIL back_to_back %0d cycle %0d: got %h expected %h", i, c, g, e); end
            @(posedge clock); #1;
            if (c == 0) ir_m = seq[i];
         end
      end
      in_valid = 1'b0;
      z_flag   = 1'b0;
   endtask

   task automatic test_in();
      logic [28:0] e, g;
      // c0 FETCH, c1 EXEC, c2..6 WAIT idle, c7 WAIT with in_valid, c8 FETCH, c9 EXEC of NOP
      for (int c = 0; c < 10; c++) begin
         in_valid = (c == 7);
         instr    = (c >= 8) ? 16'h0000 : 16'h7600;
         case (c)
            0:       sb.push_back(mk(8'h00, ir_m));
            1:       sb.push_back(mk(8'h00, 16'h7600));
            7:       sb.push_back(mk(S_RDY | S_WE | S_INSEL | S_INC, 16'h7600));
            8:       sb.push_back(mk(8'h00, 16'h7600));
            9:       sb.push_back(mk(S_INC, 16'h0000));
            default: sb.push_back(mk(S_RDY, 16'h7600));
         endcase
         @(negedge clock);
         e = sb.pop_front(); g = obs(); tests++;
         if (g !== e) begin fails++; $display("FAIL in_handshake cycle %0d: got %h expected %h", c, g, e); end
         @(posedge clock); #1;
         if (c == 0) ir_m = 16'h7600;
         if (c == 8) ir_m = 16'h0000;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      logic [28:0] e, g;
      // c0 FETCH IN, c1 EXEC, c2 WAIT (reset raised after), c3 FETCH after reset, c4 EXEC NOP
      for (int c = 0; c < 5; c++) begin
         instr = (c >= 3) ? 16'h0000 : 16'h7600;
         case (c)
            0:       sb.push_back(mk(8'h00, ir_m));
            1:       sb.push_back(mk(8'h00, 16'h7600));
            2:       sb.push_back(mk(S_RDY, 16'h7600));
            3:       sb.push_back(mk(8'h00, 16'h0000));
            default: sb.push_back(mk(S_INC, 16'h0000));
         endcase
         @(negedge clock);
         e = sb.pop_front(); g = obs(); tests++;
         if (g !== e) begin fails++; $display("FAIL reset_in_wait cycle %0d: got %h expected %h", c, g, e); end
         @(posedge clock); #1;
         if (c == 0) ir_m = 16'h7600;
         if (c == 2) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            ir_m  = 16'h0000;
         end
      end
   endtask

   task automatic test_halt();
      logic [28:0] e, g;
      for (int c = 0; c < 2; c++) begin
         instr = 16'hF000;
         sb.push_back(c == 0 ? mk(8'h00, ir_m) : mk(8'h00, 16'hF000));
         @(negedge clock);
         e = sb.pop_front(); g = obs(); tests++;
         if (g !== e) begin fails++; $display("FAIL halt_entry cycle %0d: got %h expected %h", c, g, e); end
         @(posedge clock); #1;
         if (c == 0) ir_m = 16'hF000;
      end
      strobe_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = c[0];
         instr    = 16'h1000;
         sb.push_back(mk(S_HALT, 16'hF000));
         @(negedge clock);
         e = sb.pop_front(); g = obs(); tests++;
         if (g !== e) begin fails++; $display("FAIL halt_hold cycle %0d: got %h expected %h", c, g, e); end
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      tests++;
      if (strobe_cnt !== 0) begin fails++; $display("FAIL halt_strobes: got %0d expected 0", strobe_cnt); end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      ir_m  = 16'h0000;
      sb.push_back(mk(8'h00, 16'h0000));
      @(negedge clock);
      e = sb.pop_front(); g = obs(); tests++;
      if (g !== e) begin fails++; $display("FAIL halt_reset_exit: got %h expected %h", g, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_decode();
      test_jmp();
      test_back_to_back();
      test_in();
      test_reset_in_wait();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
